cfg_pkt_initiator: RTL
======================

// Module: cfg_pkt_initiator
// PURPOSE
//  Host-side master for the 134-bit configuration-packet ring. It turns single software register commands into
//  config packets, drives them into the head of the module chain and sinks packets at the tail.
//  Reads wait for the matching read response or a timeout. Writes are posted. One transaction is in flight at a time.
// PARAMETERS
//  TIMEOUT_CYCLES  1024   cycles in WAIT_RSP before a read fails; legal range 2..65535
//  TAG_INIT        8'h00  first tag value after reset
// PORTS
//  clk            in   1    clock
//  rst_n          in   1    asynchronous, active-low reset
//  cmd_valid      in   1    host command present
//  cmd_ready      out  1    high only in IDLE
//  cmd_write      in   1    1=write, 0=read
//  cmd_addr       in   32   register address, e.g. 32'h7000000A
//  cmd_wdata      in   32   write data; ignored for reads
//  rsp_valid      out  1    read result valid; held until rsp_ready
//  rsp_ready      in   1    host consumes the result
//  rsp_rdata      out  32   read data; 0 on timeout
//  rsp_timeout    out  1    qualifies rsp_valid: read timed out
//  cout_data      out  134  packet to the first module in the ring
//  cout_data_wr   out  1    one-cycle strobe per packet
//  cin_ready      in   1    ring head can accept a packet
//  cin_data       in   134  packet returning from the ring tail
//  cin_data_wr    in   1    cin_data valid
//  cout_ready     out  1    tied 1; always sinks
// BEHAVIOUR
//  Packet format (single beat): [133:128] 6'b110000 | [127:124] opcode: 0010 write, 0001 read, 1011 read-rsp
//  | [103:96] tag | [95:64] addr | [31:0] data. All other bits are 0.
//  Reset: every output is 0 except cout_ready=1. tag=TAG_INIT. State=IDLE. Timer=0.
//  FSM states: IDLE, ISSUE, WAIT_RSP, RESP.
//  IDLE: cmd_ready=1. When cmd_valid, latch write/addr/wdata and go to ISSUE.
//  ISSUE: the packet is held while cin_ready=0. When cin_ready=1, register cout_data/cout_data_wr=1 for exactly one cycle.
//    The tag is incremented after issue, modulo 256, wrapping FF->00.
//    A write then returns to IDLE; a read clears the timer and goes to WAIT_RSP.
//  Latency: cmd accepted at cycle N with cin_ready=1 -> cout_data_wr=1 at N+2.
//  WAIT_RSP: a match requires cin_data_wr && opcode==1011 && tag==issued tag && addr==issued addr.
//    On a match: rsp_rdata=cin_data[31:0], rsp_timeout=0, go to RESP.
//    Any non-matching packet (write echo, stale tag, other opcode) is dropped without error.
//    Timer increments every cycle. When timer==TIMEOUT_CYCLES-1: rsp_rdata=0, rsp_timeout=1, go to RESP.
//    If a match and the timeout occur in the same cycle, the match wins.
//  RESP: rsp_valid=1 until rsp_ready, then clear rsp_valid/rsp_timeout and go to IDLE.
//    Ring packets arriving outside WAIT_RSP are dropped.
//  Widths: timer is 16-bit unsigned with no wrap, because it stops at the limit. Tag is 8-bit.
//  Reset mid-operation: asynchronous return to the reset state. A later late response carries an old tag and is dropped.
// CONFIGURATION
//  CFG_INIT_RETRY_EN defined: on the first timeout of a read, reissue once with a new tag (ISSUE -> WAIT_RSP).
//    Report rsp_timeout=1 only if the retry also times out. Worst-case read latency is 2*TIMEOUT_CYCLES plus issue cycles.
//  Undefined: the first timeout is reported immediately. No retry counter is synthesised.
// STRUCTURE
//  Package cfg_pkt_pkg: opcode localparams (OP_WR, OP_RD, OP_RSP), field bit positions (TAG_LSB=96, ADDR_LSB=64),
//    frame constant 6'b110000, FSM state encoding, function build_pkt(op, tag, addr, data).
//  No sub-module. The FSM, timer and response matcher form one always block plus the output registers.
// TESTING
//  1 Write 0x70000000 data 0x11, cin_ready=1 -> one cout_data_wr, opcode 0010, tag 00, back to IDLE; no rsp_valid.
//  2 Read 0x7000000A; the bench returns opcode 1011, tag 01, data 0x1234 after 20 cycles
//    -> rsp_valid, rsp_rdata=0x1234, rsp_timeout=0.
//  3 Read with no response, TIMEOUT_CYCLES=16 -> rsp_timeout=1 and rsp_rdata=0 at exactly 16 cycles after issue.
//    With CFG_INIT_RETRY_EN: a second packet is issued with tag+1.
//  4 cin_ready held low for 10 cycles during ISSUE -> no cout_data_wr; packet issued once cin_ready rises, with unchanged content.
//  5 In WAIT_RSP, inject a response with the wrong tag, then the matching one -> first dropped, second reported.
//    Also inject a match on the timeout cycle -> the data is reported.
//  6 256 writes -> tag wraps FF->00. Assert rst_n in WAIT_RSP -> all outputs reset; a late response is ignored afterwards.

Source files
------------

// File: rtl/cfg_pkt_pkg.sv
// Shared definitions for the configuration-packet ring: opcodes, field
// positions, FSM encoding and the single-beat packet builder.
package cfg_pkt_pkg;

    localparam int PKT_W     = 134;
    localparam int FRAME_LSB = 128;
    localparam int OP_LSB    = 124;
    localparam int TAG_LSB   = 96;
    localparam int ADDR_LSB  = 64;

    localparam logic [5:0] FRAME  = 6'b110000;
    localparam logic [3:0] OP_WR  = 4'b0010;
    localparam logic [3:0] OP_RD  = 4'b0001;
    localparam logic [3:0] OP_RSP = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_RESP
    } state_e;

    function automatic logic [PKT_W-1:0] build_pkt(input logic [3:0]  op,
                                                   input logic [7:0]  tag,
                                                   input logic [31:0] addr,
                                                   input logic [31:0] data);
        logic [PKT_W-1:0] pkt;
        pkt                    = '0;
        pkt[FRAME_LSB +: 6]    = FRAME;
        pkt[OP_LSB +: 4]       = op;
        pkt[TAG_LSB +: 8]      = tag;
        pkt[ADDR_LSB +: 32]    = addr;
        pkt[31:0]              = data;
        return pkt;
    endfunction

endpackage

// File: rtl/cfg_pkt_initiator.sv
// Host-side master of the config-packet ring: one register command in flight,
// posted writes, reads matched by tag/addr or timed out. CFG_INIT_RETRY_EN adds one read retry.
module cfg_pkt_initiator
    import cfg_pkt_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] TAG_INIT       = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_timeout,
    output logic [PKT_W-1:0] cout_data,
    output logic             cout_data_wr,
    input  logic             cin_ready,
    input  logic [PKT_W-1:0] cin_data,
    input  logic             cin_data_wr,
    output logic             cout_ready
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [7:0]       tag_q, tag_d;
    logic [7:0]       issued_tag_q, issued_tag_d;
    logic             wr_q, wr_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [15:0]      timer_q, timer_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic [PKT_W-1:0] cout_data_q, cout_data_d;
    logic             cout_data_wr_q, cout_data_wr_d;
`ifdef CFG_INIT_RETRY_EN
    logic             retry_q, retry_d;
`endif
    logic             rsp_match;
    logic             unused_cin_bits;

    // Only opcode, tag and address identify our response; frame and pad bits are don't-care.
    assign unused_cin_bits = ^{cin_data[PKT_W-1:OP_LSB+4], cin_data[OP_LSB-1:TAG_LSB+8],
                               cin_data[ADDR_LSB-1:32]};

    assign rsp_match = cin_data_wr
                    && (cin_data[OP_LSB +: 4]    == OP_RSP)
                    && (cin_data[TAG_LSB +: 8]   == issued_tag_q)
                    && (cin_data[ADDR_LSB +: 32] == addr_q);

    always_comb begin
        state_d        = state_q;
        tag_d          = tag_q;
        issued_tag_d   = issued_tag_q;
        wr_d           = wr_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        timer_d        = timer_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_timeout_d  = rsp_timeout_q;
        cout_data_d    = cout_data_q;
        cout_data_wr_d = 1'b0;
`ifdef CFG_INIT_RETRY_EN
        retry_d        = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    wr_d    = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_write ? cmd_wdata : 32'h0;
`ifdef CFG_INIT_RETRY_EN
                    retry_d = 1'b0;
`endif
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cin_ready) begin
                    cout_data_d    = build_pkt(wr_q ? OP_WR : OP_RD, tag_q, addr_q, wdata_q);
                    cout_data_wr_d = 1'b1;
                    issued_tag_d   = tag_q;
                    tag_d          = tag_q + 8'd1;
                    if (wr_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = 16'd0;
                        state_d = ST_WAIT_RSP;
                    end
                end
            end
            ST_WAIT_RSP: begin
                // A response landing on the timeout cycle still wins.
                if (rsp_match) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = cin_data[31:0];
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (timer_q == TMO_LAST) begin
`ifdef CFG_INIT_RETRY_EN
                    if (!retry_q) begin
                        retry_d = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = 32'h0;
                        rsp_timeout_d = 1'b1;
                        state_d       = ST_RESP;
                    end
`else
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 32'h0;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
`endif
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered so cmd_ready stays low while reset is asserted.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            tag_q          <= TAG_INIT;
            issued_tag_q   <= 8'h00;
            wr_q           <= 1'b0;
            addr_q         <= 32'h0;
            wdata_q        <= 32'h0;
            timer_q        <= 16'd0;
            cmd_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= 32'h0;
            rsp_timeout_q  <= 1'b0;
            cout_data_q    <= '0;
            cout_data_wr_q <= 1'b0;
`ifdef CFG_INIT_RETRY_EN
            retry_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            tag_q          <= tag_d;
            issued_tag_q   <= issued_tag_d;
            wr_q           <= wr_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            timer_q        <= timer_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_timeout_q  <= rsp_timeout_d;
            cout_data_q    <= cout_data_d;
            cout_data_wr_q <= cout_data_wr_d;
`ifdef CFG_INIT_RETRY_EN
            retry_q        <= retry_d;
`endif
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign cout_data    = cout_data_q;
    assign cout_data_wr = cout_data_wr_q;
    assign cout_ready   = 1'b1;

endmodule
